// File: rtl/core_pkg.sv
// Shared definitions for the fetch/decode slice: instruction field layout and fetch FSM encoding.
// Pure declarations; no logic, no latency.
// No flow control lives here.
package core_pkg;

  localparam int INST_W = 10;
  localparam int REG_W  = 3;

  localparam int OP_BIT = 9;
  localparam int RW_LSB = 6;
  localparam int RA_LSB = 3;
  localparam int RB_LSB = 0;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_MUL = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fetch_state_t;

  function automatic logic is_mul(input logic [INST_W-1:0] word);
    return word[OP_BIT] == OP_MUL;
  endfunction

  function automatic logic [REG_W-1:0] field_rw(input logic [INST_W-1:0] word);
    return word[RW_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] field_ra(input logic [INST_W-1:0] word);
    return word[RA_LSB +: REG_W];
  endfunction

  function automatic logic [REG_W-1:0] field_rb(input logic [INST_W-1:0] word);
    return word[RB_LSB +: REG_W];
  endfunction

endpackage

// File: rtl/inst_fetch_if.sv
// Loader/control inputs and the instruction stream towards decode.
// Wires only; master is the fetch unit, slave is the loader plus decode side.
// Backpressure is the stall signal driven by the slave side.
interface inst_fetch_if #(
  parameter int DEPTH = 16
);
  import core_pkg::*;

  localparam int AW = $clog2(DEPTH);

  logic              prog_we;
  logic [AW-1:0]     prog_addr;
  logic [INST_W-1:0] prog_data;
  logic [AW:0]       prog_len;
  logic              start;
  logic              stall;

  logic [INST_W-1:0] inst;
  logic              valid_pc;
  logic [AW-1:0]     pc;
  logic              busy;
  logic              done;

  modport master (
    input  prog_we, prog_addr, prog_data, prog_len, start, stall,
    output inst, valid_pc, pc, busy, done
  );

  modport slave (
    output prog_we, prog_addr, prog_data, prog_len, start, stall,
    input  inst, valid_pc, pc, busy, done
  );

endinterface

// File: rtl/inst_rom.sv
// Program store: DEPTH x INST_W register array, one synchronous write port.
// Read is combinational (zero latency); contents are never reset.
// No backpressure; the caller gates the write enable.
module inst_rom
  import core_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);

  logic [INST_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: streams a loaded program to decode, one instruction per cycle.
// First valid_pc one cycle after start; outputs registered.
// stall freezes inst/pc/valid_pc; loader writes and start are ignored while running.
module inst_fetch
  import core_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE_L   = (AW+1)'(1);

  logic [1:0]        state;
  logic [AW:0]       next_pc;
  logic [AW:0]       len;
  logic [INST_W-1:0] inst_q;
  logic              valid_q;
  logic [AW-1:0]     pc_q;
  logic              busy_q;
  logic              done_q;

  logic              ctrl_open;
  logic              rom_we;
  logic [AW-1:0]     rom_raddr;
  logic [INST_W-1:0] rom_rdata;
  logic [AW:0]       len_clamped;
  logic              xfer;

  assign ctrl_open   = (state != ST_RUN);
  // start wins over a same-cycle write so the run sees the pre-existing program
  assign rom_we      = ctrl_open && bus.prog_we && !bus.start;
  assign rom_raddr   = ctrl_open ? '0 : next_pc[AW-1:0];
  assign len_clamped = (bus.prog_len > DEPTH_L) ? DEPTH_L : bus.prog_len;
  assign xfer        = valid_q && !bus.stall;

  inst_rom #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_rom (
    .clk   (clk),
    .we    (rom_we),
    .waddr (bus.prog_addr),
    .wdata (bus.prog_data),
    .raddr (rom_raddr),
    .rdata (rom_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      next_pc <= '0;
      len     <= '0;
      inst_q  <= '0;
      valid_q <= 1'b0;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            len <= len_clamped;
            if (len_clamped == '0) begin
              state   <= ST_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state   <= ST_RUN;
              inst_q  <= rom_rdata;
              pc_q    <= '0;
              valid_q <= 1'b1;
              next_pc <= ONE_L;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
        ST_RUN: begin
          if (xfer) begin
            // next_pc is one bit wider than the address, so len == DEPTH ends cleanly
            if (next_pc < len) begin
              inst_q  <= rom_rdata;
              pc_q    <= next_pc[AW-1:0];
              next_pc <= next_pc + ONE_L;
            end else begin
              state   <= ST_DONE;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state   <= ST_IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.inst     = inst_q;
  assign bus.valid_pc = valid_q;
  assign bus.pc       = pc_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule

// File: tb/tb_inst_fetch.sv
// Randomized self-checking bench for inst_fetch against an array-and-index program model.
module tb_inst_fetch;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [9:0] mem_m [DEPTH];

  inst_fetch_if #(.DEPTH(DEPTH)) bus ();

  inst_fetch #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int addr, input logic [9:0] data);
    bus.prog_we   = 1'b1;
    bus.prog_addr = addr[3:0];
    bus.prog_data = data;
    step();
    bus.prog_we   = 1'b0;
    mem_m[addr]   = data;
  endtask

  // Expected stream: mem_m[0..n-1] in order, one item consumed per non-stalled cycle.
  task automatic do_run(input int plen, input int stall_pct, input int hold_at, input int hold_cnt,
                        input bit disturb, input bit we_on_start, input string name);
    int n, idx, held, cyc;
    n = (plen > DEPTH) ? DEPTH : plen;
    bus.prog_len = plen[4:0];
    bus.start    = 1'b1;
    if (we_on_start) begin
      bus.prog_we   = 1'b1;
      bus.prog_addr = 4'd2;
      bus.prog_data = ~mem_m[2];
    end
    step();
    bus.start   = 1'b0;
    bus.prog_we = 1'b0;
    if (n == 0) begin
      checks++;
      if ({bus.valid_pc, bus.busy, bus.done} !== 3'b001) begin
        errors++;
        $display("FAIL %s zero_len_done: got v/b/d=%b expected 001", name, {bus.valid_pc, bus.busy, bus.done});
      end
      for (int k = 0; k < 3; k++) begin
        step();
        checks++;
        if (bus.valid_pc !== 1'b0) begin
          errors++;
          $display("FAIL %s zero_len_valid: got %b expected 0", name, bus.valid_pc);
        end
      end
      return;
    end
    idx = 0; held = 0; cyc = 0;
    while (idx < n && cyc < 400) begin
      checks++;
      if ({bus.valid_pc, bus.busy, bus.done, bus.pc, bus.inst} !== {1'b1, 1'b1, 1'b0, 4'(idx), mem_m[idx]}) begin
        errors++;
        $display("FAIL %s stream[%0d]: got v=%b b=%b d=%b pc=%0d inst=%h expected v=1 b=1 d=0 pc=%0d inst=%h",
                 name, idx, bus.valid_pc, bus.busy, bus.done, bus.pc, bus.inst, idx, mem_m[idx]);
      end
      bus.stall = 1'b0;
      if (idx == hold_at && held < hold_cnt) begin
        bus.stall = 1'b1;
        held++;
      end else if (int'($urandom_range(99)) < stall_pct) begin
        bus.stall = 1'b1;
      end
      if (disturb) begin
        bus.start     = 1'($urandom_range(1));
        bus.prog_we   = 1'b1;
        bus.prog_addr = 4'($urandom);
        bus.prog_data = 10'($urandom);
      end
      if (!bus.stall) idx++;
      step();
      cyc++;
      bus.start   = 1'b0;
      bus.prog_we = 1'b0;
    end
    bus.stall = 1'b0;
    if (idx < n) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got %0d transfers expected %0d", name, idx, n);
    end
    checks++;
    if ({bus.valid_pc, bus.busy, bus.done} !== 3'b001) begin
      errors++;
      $display("FAIL %s end_of_run: got v/b/d=%b expected 001", name, {bus.valid_pc, bus.busy, bus.done});
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.valid_pc, bus.busy, bus.done, bus.pc, bus.inst} !== 17'd0) begin
      errors++;
      $display("FAIL reset_state: got v=%b b=%b d=%b pc=%0d inst=%h expected all 0",
               bus.valid_pc, bus.busy, bus.done, bus.pc, bus.inst);
    end
    step();
    rst = 1'b0;
    step();
    checks++;
    if ({bus.valid_pc, bus.busy, bus.done} !== 3'b000) begin
      errors++;
      $display("FAIL reset_idle: got v/b/d=%b expected 000", {bus.valid_pc, bus.busy, bus.done});
    end
  endtask

  task automatic test_load_and_run();
    load(0, 10'h000);
    load(1, 10'h253);
    load(2, 10'h3FF);
    do_run(3, 0, -1, 0, 1'b0, 1'b0, "load_run");
  endtask

  task automatic test_stall_hold();
    do_run(3, 0, 1, 4, 1'b0, 1'b0, "stall_hold");
  endtask

  task automatic test_rerun_from_done();
    do_run(3, 40, -1, 0, 1'b0, 1'b0, "rerun_done");
  endtask

  task automatic test_zero_and_over_length();
    do_run(0, 0, -1, 0, 1'b0, 1'b0, "zero_len");
    for (int a = 0; a < DEPTH; a++) load(a, 10'($urandom));
    do_run(20, 0, -1, 0, 1'b0, 1'b0, "over_len");
    do_run(31, 30, -1, 0, 1'b0, 1'b0, "over_len_stall");
    do_run(16, 0, -1, 0, 1'b0, 1'b0, "full_len");
  endtask

  task automatic test_ignored_controls();
    load(0, 10'h000);
    load(1, 10'h253);
    load(2, 10'h3FF);
    do_run(3, 30, -1, 0, 1'b1, 1'b0, "ignored_run");
    do_run(16, 0, -1, 0, 1'b0, 1'b0, "ignored_after");
    do_run(3, 0, -1, 0, 1'b0, 1'b1, "start_we");
    do_run(3, 0, -1, 0, 1'b0, 1'b0, "start_we_after");
  endtask

  task automatic test_reset_mid_run();
    bus.prog_len = 5'd3;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    step();
    checks++;
    if ({bus.valid_pc, bus.pc, bus.inst} !== {1'b1, 4'd1, mem_m[1]}) begin
      errors++;
      $display("FAIL mid_run_pre: got v=%b pc=%0d inst=%h expected v=1 pc=1 inst=%h",
               bus.valid_pc, bus.pc, bus.inst, mem_m[1]);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({bus.valid_pc, bus.busy, bus.done, bus.pc, bus.inst} !== 17'd0) begin
      errors++;
      $display("FAIL mid_run_async_reset: got v=%b b=%b d=%b pc=%0d inst=%h expected all 0",
               bus.valid_pc, bus.busy, bus.done, bus.pc, bus.inst);
    end
    step();
    rst = 1'b0;
    step();
    do_run(3, 0, -1, 0, 1'b0, 1'b0, "replay");
  endtask

  task automatic test_random();
    for (int r = 0; r < 25; r++) begin
      for (int w = 0; w < int'($urandom_range(3)); w++) load(int'($urandom_range(DEPTH-1)), 10'($urandom));
      do_run(int'($urandom_range(31)), 35, -1, 0, 1'($urandom_range(1)), 1'($urandom_range(1)), "random");
    end
  endtask

  initial begin
    bus.prog_we   = 1'b0;
    bus.prog_addr = '0;
    bus.prog_data = '0;
    bus.prog_len  = '0;
    bus.start     = 1'b0;
    bus.stall     = 1'b0;
    test_reset();
    test_load_and_run();
    test_stall_hold();
    test_rerun_from_done();
    test_zero_and_over_length();
    test_ignored_controls();
    test_reset_mid_run();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_fetch.md
# inst_fetch

Instruction fetch unit that produces the 10-bit instruction stream (`inst`, `valid_pc`) consumed by the decode stage. It holds a small loadable program store, a program counter and a run/stall handshake. A loader writes instructions while the unit is idle. A `start` pulse then streams them in order to decode, holding the current instruction whenever the back end asserts `stall`.

## Interface
- `DEPTH`, 16: program store entries (power of two, ≥2); `AW = $clog2(DEPTH)`.
- `clk  in  1`: clock; all state updates on the rising edge.
- `rst  in  1`: asynchronous, active-high reset.
- `prog_we  in  1`: program store write enable; honoured only in IDLE or DONE.
- `prog_addr  in  AW`: write address.
- `prog_data  in  10`: instruction word. Bit 9 is the opcode (0 = add, 1 = mul); bits [8:0] are {Rw, Ra, Rb}.
- `prog_len  in  AW+1`: number of instructions to run; sampled on `start`; values > DEPTH are clamped to DEPTH.
- `start  in  1`: begin a run; honoured only in IDLE or DONE.
- `stall  in  1`: downstream not ready; holds the current instruction.
- `inst  out  10`: current instruction; registered.
- `valid_pc  out  1`: `inst` is valid; registered.
- `pc  out  AW`: address of `inst`; registered.
- `busy  out  1`: high in RUN.
- `done  out  1`: high in DONE; stays high until the next `start` or reset.

## Operation
- States: IDLE, RUN, DONE.
- Reset values: state = IDLE, `inst` = 0, `valid_pc` = 0, `pc` = 0, `busy` = 0, `done` = 0, internal `next_pc` = 0, latched length = 0. Program store contents are not reset.
- IDLE/DONE with `prog_we`: `mem[prog_addr] <= prog_data`.
- IDLE/DONE with `start`:
  - If the clamped length is 0: go to DONE; `valid_pc` stays 0.
  - Otherwise: go to RUN with `inst <= mem[0]`, `pc <= 0`, `valid_pc <= 1`, `next_pc <= 1`.
  - If `prog_we` is asserted in the same cycle, `start` wins and the write is dropped.
- RUN:
  - A transfer occurs in any cycle with `valid_pc && !stall`.
  - On a transfer with `next_pc < len`: `inst <= mem[next_pc]`, `pc <= next_pc`, `next_pc <= next_pc + 1`.
  - On a transfer with `next_pc == len`: `valid_pc <= 0`, go to DONE.
  - When `stall` is high, `inst`, `pc` and `valid_pc` hold their values exactly.
  - `prog_we` and `start` are ignored in RUN.
- `next_pc` is AW+1 bits wide, so `len == DEPTH` terminates without address wrap. The store is read with the low AW bits only.

## Timing
- Latency from `start` to first `valid_pc` is 1 cycle: `valid_pc` is high in the cycle after `start` is sampled.
- With `stall` held low, a run of N instructions presents one instruction per cycle for N cycles.
  - `valid_pc` falls and `done` rises together, in the cycle after the Nth transfer.
- The store read is asynchronous (combinational). A write becomes visible to any `start` that comes at least one cycle later.
- `stall` is sampled every cycle; it has no effect when `valid_pc` = 0.
- Asserting reset mid-run drops any in-flight instruction. All outputs return to reset values asynchronously and the program store is kept. A `start` after reset deasserts replays the program from pc 0.
- `start` in DONE reruns the program immediately; no IDLE visit is needed.

## Structure
- Shared package `core_pkg` holds:
  - `INST_W = 10`, `REG_W = 3`.
  - Field positions: `OP_BIT = 9`, Rw [8:6], Ra [5:3], Rb [2:0].
  - `OP_ADD = 1'b0`, `OP_MUL = 1'b1`.
  - FSM enum `fetch_state_t {IDLE, RUN, DONE}`.
- One sub-module, `inst_rom`: a DEPTH × INST_W register array with a single write port and an asynchronous read port.
- `inst_fetch` contains the FSM, `next_pc`, the length latch and the output registers.

## Test plan
- **Load and run:** write 0x000, 0x253, 0x3FF to addresses 0–2, then `prog_len` = 3 and `start`, with `stall` = 0.
  - `inst` = 0x000, 0x253, 0x3FF on three consecutive cycles, `pc` = 0, 1, 2.
  - Next cycle: `valid_pc` = 0, `done` = 1.
- **Stall hold:** same program, `stall` = 1 for 4 cycles while `pc` = 1.
  - `inst` holds 0x253 and `valid_pc` holds 1 for all 4 cycles; `pc` = 2 follows on the first cycle after `stall` drops.
- **Zero and over-length:** `prog_len` = 0 then `start` gives `done` = 1 next cycle and `valid_pc` never asserts. With `prog_len` = 20 and DEPTH = 16, exactly 16 transfers occur, `pc` runs 0..15 and no wrap occurs.
- **Ignored controls:** `prog_we` to address 1 and `start` pulses during RUN leave both the program and the sequence unchanged.
  - `start` with `prog_we` in the same cycle in IDLE: the run begins and the write is dropped.
- **Reset mid-run:** assert `rst` at `pc` = 1.
  - `valid_pc`, `inst`, `pc` and `busy` go to 0 immediately.
  - After release, `start` replays from `inst` = 0x000 (store retained).
- **Rerun from DONE:** `start` in DONE gives `valid_pc` = 1 with `pc` = 0 on the next cycle and `done` = 0.
